// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI responder.
// Mode constants are packed as {cpol, cpha}.
package spi_slave_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    typedef enum logic {
        StIdle,
        StXfer
    } state_t;

endpackage

// File: rtl/spi_slave_if.sv
// Pad-side and client-side signals of the SPI responder, grouped into one bundle.
// The slave modport is the responder's view; the master modport is the pads/client view.
interface spi_slave_if #(
    parameter int unsigned DATA_WIDTH = spi_slave_pkg::DEFAULT_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] din;
    logic                  tx_wr;
    logic                  tx_empty;
    logic [DATA_WIDTH-1:0] dout;
    logic                  rx_done_tick;
    logic                  tx_underrun_tick;
    logic                  busy;
    logic                  cpol;
    logic                  cpha;
    logic                  sclk;
    logic                  ss_n;
    logic                  mosi;
    logic                  miso;
    logic                  miso_oe;

    modport slave (
        input  din, tx_wr, cpol, cpha, sclk, ss_n, mosi,
        output tx_empty, dout, rx_done_tick, tx_underrun_tick, busy, miso, miso_oe
    );

    modport master (
        output din, tx_wr, cpol, cpha, sclk, ss_n, mosi,
        input  tx_empty, dout, rx_done_tick, tx_underrun_tick, busy, miso, miso_oe
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop pin synchronizer with rise/fall detection against one history flop.
module spi_sync_edge #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = q & ~hist_q;
    assign fall = ~q & hist_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder: oversamples sclk/ss_n/mosi on clk, shifts a word in from mosi while
// shifting the buffered transmit word out on miso, in any cpol/cpha mode.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    spi_slave_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic sclk_rise, sclk_fall, sclk_unused_q;
    logic ss_q, ss_fall, ss_edge_unused_rise;
    logic mosi_q;
    logic [1:0] mosi_edge_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .d(bus.sclk),
        .q(sclk_unused_q), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk(clk), .reset(reset), .d(bus.ss_n),
        .q(ss_q), .rise(ss_edge_unused_rise), .fall(ss_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .d(bus.mosi),
        .q(mosi_q), .rise(mosi_edge_unused[1]), .fall(mosi_edge_unused[0])
    );

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_in_q, shift_in_d;
    logic [DATA_WIDTH-1:0] shift_out_q, shift_out_d;
    logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  tx_empty_q, tx_empty_d;
    logic                  done_seen_q, done_seen_d;
    logic                  mode_cpol_q, mode_cpol_d;
    logic                  mode_cpha_q, mode_cpha_d;
    logic                  rx_tick_q, rx_tick_d;
    logic                  under_tick_q, under_tick_d;
    logic                  leading, trailing, sample_edge, shift_edge, load;

    // Edges are classified with the mode latched at frame start, not the live pins.
    assign leading     = mode_cpol_q ? sclk_fall : sclk_rise;
    assign trailing    = mode_cpol_q ? sclk_rise : sclk_fall;
    assign sample_edge = mode_cpha_q ? trailing : leading;
    assign shift_edge  = mode_cpha_q ? leading : trailing;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            shift_in_q   <= '0;
            shift_out_q  <= '0;
            tx_buf_q     <= '0;
            dout_q       <= '0;
            tx_empty_q   <= 1'b1;
            done_seen_q  <= 1'b0;
            mode_cpol_q  <= 1'b0;
            mode_cpha_q  <= 1'b0;
            rx_tick_q    <= 1'b0;
            under_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_in_q   <= shift_in_d;
            shift_out_q  <= shift_out_d;
            tx_buf_q     <= tx_buf_d;
            dout_q       <= dout_d;
            tx_empty_q   <= tx_empty_d;
            done_seen_q  <= done_seen_d;
            mode_cpol_q  <= mode_cpol_d;
            mode_cpha_q  <= mode_cpha_d;
            rx_tick_q    <= rx_tick_d;
            under_tick_q <= under_tick_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_in_d   = shift_in_q;
        shift_out_d  = shift_out_q;
        tx_buf_d     = tx_buf_q;
        dout_d       = dout_q;
        tx_empty_d   = tx_empty_q;
        done_seen_d  = done_seen_q;
        mode_cpol_d  = mode_cpol_q;
        mode_cpha_d  = mode_cpha_q;
        rx_tick_d    = 1'b0;
        under_tick_d = 1'b0;
        load         = 1'b0;

        case (state_q)
            StIdle: begin
                if (ss_fall) begin
                    state_d     = StXfer;
                    mode_cpol_d = bus.cpol;
                    mode_cpha_d = bus.cpha;
                    bit_cnt_d   = '0;
                    done_seen_d = 1'b0;
                    load        = 1'b1;
                end
            end
            StXfer: begin
                // Deselect takes priority over any sclk edge seen in the same cycle.
                if (ss_q) begin
                    state_d = StIdle;
                end else if (sample_edge) begin
                    shift_in_d = {shift_in_q[DATA_WIDTH-2:0], mosi_q};
                    if (bit_cnt_q == LAST_BIT) begin
                        dout_d      = shift_in_d;
                        rx_tick_d   = 1'b1;
                        bit_cnt_d   = '0;
                        done_seen_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (shift_edge) begin
                    if (bit_cnt_q != '0) begin
                        shift_out_d = {shift_out_q[DATA_WIDTH-2:0], 1'b0};
                    end else if (done_seen_q) begin
                        load = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            shift_out_d  = tx_buf_q;
            tx_empty_d   = 1'b1;
            under_tick_d = tx_empty_q;
        end
        // A write coinciding with a load refills the buffer after the old word was taken.
        if (bus.tx_wr) begin
            tx_buf_d   = bus.din;
            tx_empty_d = 1'b0;
        end
    end

    assign bus.busy             = (state_q == StXfer);
    assign bus.miso_oe          = (state_q == StXfer);
    assign bus.miso             = shift_out_q[DATA_WIDTH-1];
    assign bus.dout             = dout_q;
    assign bus.tx_empty         = tx_empty_q;
    assign bus.rx_done_tick     = rx_tick_q;
    assign bus.tx_underrun_tick = under_tick_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a table of single-word frames in all modes, plus
// hand-written multi-word, abort and mid-frame reset sequences.
module tb_spi_slave;
    import spi_slave_pkg::*;

    localparam int DW         = 8;
    localparam int SS         = 2;
    localparam int HALF       = 4;
    localparam int CLK_PERIOD = 10;

    logic clk = 1'b0;
    logic reset;
    always #(CLK_PERIOD / 2) clk = ~clk;

    spi_slave_if #(.DATA_WIDTH(DW)) bus ();

    spi_slave #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]    mode;
        logic [DW-1:0] tx;
        logic [DW-1:0] mosi;
        logic [DW-1:0] exp_dout;
        logic [DW-1:0] exp_miso;
    } vec_t;

    vec_t vecs[5];

    int checks = 0;
    int errors = 0;
    int rx_ticks = 0;
    int under_ticks = 0;
    time tick_time = 0;
    time last_sample = 0;
    logic [DW-1:0] miso_cap;
    logic [DW-1:0] first_word;
    logic cur_pol, cur_pha;
    int rx_base, under_base;

    always @(negedge clk) begin
        if (bus.rx_done_tick) begin
            rx_ticks  = rx_ticks + 1;
            tick_time = $time;
        end
        if (bus.tx_underrun_tick) under_ticks = under_ticks + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_tx(input logic [DW-1:0] v);
        bus.din   = v;
        bus.tx_wr = 1'b1;
        wait_clk(1);
        bus.tx_wr = 1'b0;
    endtask

    task automatic frame_start(input logic pol, input logic pha);
        bus.cpol = pol;
        bus.cpha = pha;
        bus.sclk = pol;
        cur_pol  = pol;
        cur_pha  = pha;
        wait_clk(6);
        bus.ss_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic frame_end;
        wait_clk(HALF);
        bus.ss_n = 1'b1;
        wait_clk(6);
    endtask

    // Drives bits hi..lo of b MSB first and captures miso just before each sample edge.
    task automatic shift_bits(input logic [DW-1:0] b, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            if (!cur_pha) begin
                bus.mosi = b[i];
                wait_clk(HALF);
                miso_cap[i] = bus.miso;
                bus.sclk    = ~cur_pol;
                last_sample = $time;
                wait_clk(HALF);
                bus.sclk = cur_pol;
            end else begin
                bus.sclk = ~cur_pol;
                bus.mosi = b[i];
                wait_clk(HALF);
                miso_cap[i] = bus.miso;
                bus.sclk    = cur_pol;
                last_sample = $time;
                wait_clk(HALF);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dout"}, int'(bus.dout), 0);
        check({tag, "_tx_empty"}, int'(bus.tx_empty), 1);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_miso_oe"}, int'(bus.miso_oe), 0);
        check({tag, "_miso"}, int'(bus.miso), 0);
        check({tag, "_rx_tick"}, int'(bus.rx_done_tick), 0);
        check({tag, "_under_tick"}, int'(bus.tx_underrun_tick), 0);
    endtask

    initial begin
        vecs[0] = '{SPI_MODE0, 8'hA5, 8'h3C, 8'h3C, 8'hA5};
        vecs[1] = '{SPI_MODE1, 8'hA5, 8'h3C, 8'h3C, 8'hA5};
        vecs[2] = '{SPI_MODE2, 8'hA5, 8'h3C, 8'h3C, 8'hA5};
        vecs[3] = '{SPI_MODE3, 8'hA5, 8'h3C, 8'h3C, 8'hA5};
        vecs[4] = '{SPI_MODE0, 8'h5A, 8'hC3, 8'hC3, 8'h5A};

        reset    = 1'b1;
        bus.din  = '0;
        bus.tx_wr = 1'b0;
        bus.cpol = 1'b0;
        bus.cpha = 1'b0;
        bus.sclk = 1'b0;
        bus.ss_n = 1'b1;
        bus.mosi = 1'b0;
        cur_pol  = 1'b0;
        cur_pha  = 1'b0;
        miso_cap = '0;
        wait_clk(3);
        check_reset_outputs("por");
        reset = 1'b0;
        wait_clk(3);

        // Single-word frames in every mode.
        for (int v = 0; v < 5; v++) begin
            rx_base = rx_ticks;
            write_tx(vecs[v].tx);
            frame_start(vecs[v].mode[1], vecs[v].mode[0]);
            shift_bits(vecs[v].mosi, DW - 1, 0);
            frame_end();
            check($sformatf("v%0d_miso", v), int'(miso_cap), int'(vecs[v].exp_miso));
            check($sformatf("v%0d_dout", v), int'(bus.dout), int'(vecs[v].exp_dout));
            check($sformatf("v%0d_ticks", v), rx_ticks - rx_base, 1);
            check($sformatf("v%0d_tx_empty", v), int'(bus.tx_empty), 1);
            check($sformatf("v%0d_busy", v), int'(bus.busy), 0);
            check($sformatf("v%0d_latency", v), int'(tick_time - last_sample),
                  (SS + 1) * CLK_PERIOD);
        end

        // Two words, second buffer write lands during word 1.
        rx_base    = rx_ticks;
        under_base = under_ticks;
        write_tx(8'hF0);
        frame_start(1'b0, 1'b1);
        shift_bits(8'h81, 7, 4);
        write_tx(8'h0F);
        shift_bits(8'h81, 3, 0);
        first_word = miso_cap;
        shift_bits(8'h7E, 7, 0);
        frame_end();
        check("two_miso0", int'(first_word), 8'hF0);
        check("two_miso1", int'(miso_cap), 8'h0F);
        check("two_ticks", rx_ticks - rx_base, 2);
        check("two_dout", int'(bus.dout), 8'h7E);
        check("two_underrun", under_ticks - under_base, 0);

        // Two words with a single write: resend and one underrun at the word-2 load.
        rx_base    = rx_ticks;
        under_base = under_ticks;
        write_tx(8'h55);
        frame_start(1'b0, 1'b1);
        shift_bits(8'h12, 7, 0);
        first_word = miso_cap;
        check("under_after_w1", under_ticks - under_base, 0);
        shift_bits(8'h34, 7, 0);
        frame_end();
        check("under_miso0", int'(first_word), 8'h55);
        check("under_miso1", int'(miso_cap), 8'h55);
        check("under_count", under_ticks - under_base, 1);
        check("under_dout", int'(bus.dout), 8'h34);

        // Deselect after 5 bits: partial word discarded.
        rx_base = rx_ticks;
        write_tx(8'h3C);
        frame_start(1'b0, 1'b0);
        check("abort_busy_on", int'(bus.busy), 1);
        shift_bits(8'hFF, 7, 3);
        bus.ss_n = 1'b1;
        wait_clk(SS + 1);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_miso_oe", int'(bus.miso_oe), 0);
        wait_clk(4);
        check("abort_ticks", rx_ticks - rx_base, 0);
        check("abort_dout", int'(bus.dout), 8'h34);
        rx_base = rx_ticks;
        write_tx(8'h69);
        frame_start(1'b0, 1'b0);
        shift_bits(8'h96, 7, 0);
        frame_end();
        check("abort_next_dout", int'(bus.dout), 8'h96);
        check("abort_next_miso", int'(miso_cap), 8'h69);
        check("abort_next_ticks", rx_ticks - rx_base, 1);

        // Reset mid-frame after 3 bits.
        write_tx(8'hE7);
        frame_start(1'b0, 1'b0);
        shift_bits(8'hFF, 7, 5);
        reset = 1'b1;
        #1;
        check_reset_outputs("mid");
        bus.ss_n = 1'b1;
        bus.sclk = 1'b0;
        bus.mosi = 1'b0;
        wait_clk(2);
        reset = 1'b0;
        wait_clk(4);
        rx_base = rx_ticks;
        write_tx(8'h5A);
        frame_start(1'b0, 1'b0);
        shift_bits(8'hC3, 7, 0);
        frame_end();
        check("rst_next_dout", int'(bus.dout), 8'hC3);
        check("rst_next_miso", int'(miso_cap), 8'h5A);
        check("rst_next_ticks", rx_ticks - rx_base, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI peripheral (responder) for the same byte-oriented serial link that the team's SPI controller drives.
- Oversamples the external sclk, ss_n and mosi pins on the system clock. Shifts a byte in from mosi while shifting a buffered byte out on miso.
- Supports all four cpol/cpha modes and back-to-back bytes within one ss_n frame.
- Sits between the pads and a register or FIFO client on the system-clock side.

Parameters:
- DATA_WIDTH, 8, bits per transfer word (must be ≥2).
- SYNC_STAGES, 2, flip-flop depth of the pin synchronizers (must be ≥2).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- din  input  DATA_WIDTH  word to transmit next.
- tx_wr  input  1  write strobe that loads din into the transmit buffer.
- tx_empty  output  1  transmit buffer has been consumed and needs a new word.
- dout  output  DATA_WIDTH  last fully received word.
- rx_done_tick  output  1  one-clk pulse when dout is updated.
- tx_underrun_tick  output  1  one-clk pulse when a word is loaded for shifting while tx_empty=1.
- busy  output  1  frame in progress (synchronized ss_n is low).
- cpol  input  1  clock idle level.
- cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge.
- sclk  input  1  SPI clock from the controller (asynchronous).
- ss_n  input  1  active-low select (asynchronous).
- mosi  input  1  serial data in (asynchronous).
- miso  output  1  serial data out, MSB first.
- miso_oe  output  1  pad output enable for miso.

Behaviour:
- Reset values:
  - Synchronizers: sclk chain = 0, ss_n chain = 1, mosi chain = 0.
  - Registers: state=IDLE, bit_cnt=0, shift_in=0, shift_out=0, tx_buf=0, dout=0.
  - Flags: tx_empty=1, busy=0, miso_oe=0, miso=0, both ticks=0.
  - Reset mid-frame aborts the frame immediately; no tick is issued.
- Synchronization and edge detection:
  - Each of sclk, ss_n and mosi passes through SYNC_STAGES flops.
  - Edges are detected against one extra history flop.
  - Constraint: sclk frequency ≤ clk/8.
- Edge classification:
  - Leading edge = transition away from cpol; trailing edge = transition back to cpol.
  - sample_edge = leading if cpha=0, else trailing.
  - shift_edge = the opposite edge.
- Transmit buffer:
  - tx_wr loads din into tx_buf and clears tx_empty. tx_wr is accepted in any state.
  - A load into shift_out copies tx_buf and sets tx_empty=1.
  - If tx_empty was already 1 at that load, tx_buf is resent and tx_underrun_tick pulses.
  - tx_wr in the same cycle as a load: shift_out takes the old tx_buf, tx_buf takes din, tx_empty ends at 0.
- FSM states:
  - IDLE: on the synchronized ss_n falling edge, latch cpol/cpha into mode registers, load shift_out, set bit_cnt=0, set done_seen=0, then go to XFER.
  - XFER, on sample_edge: shift_in ← {shift_in[DATA_WIDTH-2:0], mosi_sync}. If bit_cnt=DATA_WIDTH-1, then dout ← the new shift_in value, rx_done_tick=1, bit_cnt=0, done_seen=1; otherwise bit_cnt+1.
  - XFER, on shift_edge: if bit_cnt≠0, shift shift_out left by one with 0 fill. If bit_cnt=0 and done_seen=1, reload shift_out (start of the next word). Otherwise no action; this covers the first leading edge in cpha=1.
  - XFER, on synchronized ss_n high: return to IDLE. A partial word is discarded, with no tick, and dout is unchanged.
- Outputs:
  - miso = shift_out[DATA_WIDTH-1].
  - miso_oe = busy = (state==XFER).
  - cpol/cpha changes while busy are ignored until the next frame.
- Latency: rx_done_tick asserts SYNC_STAGES+1 clk cycles after the last sample edge at the sclk pin.
- Simultaneous sclk edge and ss_n rise in the same cycle: ss_n wins; the frame ends and the edge is ignored.

Decomposition:
- Shared package:
  - State encoding (IDLE/XFER).
  - Mode constants (SPI_MODE0..3 as {cpol,cpha}).
  - Default DATA_WIDTH.
- One natural sub-module, spi_sync_edge: a parameterized synchronizer plus rise/fall detector, instantiated for sclk, ss_n and mosi (edges unused for mosi).

Test Plan:
- Mode 0, clk:sclk=8:1, tx_wr din=8'hA5 then frame sending mosi 8'h3C. Required: miso shows 1,0,1,0,0,1,0,1; dout=8'h3C; one rx_done_tick; tx_empty=1 afterwards.
- Modes 1/2/3, same bytes. Required: identical dout and miso sequence, with sampling on the correct edge per mode; first miso bit valid before the first sample edge.
- Two-byte frame (mosi 8'h81, 8'h7E) with tx_wr 8'hF0, then 8'h0F written during byte 1. Required: miso sends F0 then 0F; two ticks; dout ends at 8'h7E; no underrun.
- Two-byte frame with only one tx_wr (8'h55). Required: 8'h55 sent twice; tx_underrun_tick pulses once, at the byte-2 load.
- ss_n deasserted after 5 bits. Required: no rx_done_tick; dout keeps its prior value; busy=0 and miso_oe=0 within SYNC_STAGES+1 clk; next frame receives correctly.
- Reset asserted mid-frame after 3 bits. Required: all outputs return to reset values; following mode-0 frame with 8'hC3 gives dout=8'hC3.
